// File: rtl/video_timing_pattern_gen_if.sv
// rtl/video_timing_pattern_gen_if.sv - Pattern control and de/hs/vs/RGB video bus of the timing generator
interface video_timing_pattern_gen_if #(
  parameter int COLOR_W = 8
);
  logic               en;
  logic [2:0]         mode;
  logic               de;
  logic               hs;
  logic               vs;
  logic [COLOR_W-1:0] r;
  logic [COLOR_W-1:0] g;
  logic [COLOR_W-1:0] b;
  logic [11:0]        x;
  logic [11:0]        y;
  logic               line_start;
  logic               frame_start;

  modport master (
    input  en, mode,
    output de, hs, vs, r, g, b, x, y, line_start, frame_start
  );

  modport slave (
    output en, mode,
    input  de, hs, vs, r, g, b, x, y, line_start, frame_start
  );
endinterface

// File: rtl/video_timing_pattern_gen.sv
// rtl/video_timing_pattern_gen.sv - Parametrised video timing and test-pattern generator
// Define VTPG_ANIMATE_EN to scroll the ramp and checkerboard patterns one pixel per frame.
module video_timing_pattern_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int COLOR_W    = 8,
  parameter int GRAD_SHIFT = 2,
  parameter int CHECK_LOG2 = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  video_timing_pattern_gen_if.master  vid
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] HS_FIRST = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_LAST  = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [11:0] VS_FIRST = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_LAST  = 12'(V_ACTIVE + V_FP + V_SYNC - 1);

  generate
    if (H_ACTIVE > 4095 || V_ACTIVE > 4095 || H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_param_check
      $error("video_timing_pattern_gen: timing does not fit 12-bit counters");
    end
  endgenerate

  logic [11:0]        h_cnt;
  logic [11:0]        v_cnt;
  logic [11:0]        xs;
  logic [2:0]         mode_q;
  logic [2:0]         bar_idx;
  logic               active;
  logic               h_last;
  logic               v_last;
  logic               chk;
  logic [COLOR_W-1:0] grey;
  logic [COLOR_W-1:0] r_n;
  logic [COLOR_W-1:0] g_n;
  logic [COLOR_W-1:0] b_n;

  assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign h_last = (h_cnt == H_LAST);
  assign v_last = (v_cnt == V_LAST);

`ifdef VTPG_ANIMATE_EN
  logic [11:0] offset;

  // Advances on the same boundary where mode_q is sampled, so a frame is drawn with one offset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      offset <= '0;
    end else if (vid.en && h_last && v_last) begin
      offset <= offset + 12'd1;
    end
  end

  assign xs = h_cnt + offset;
`else
  assign xs = h_cnt;
`endif

  assign grey = COLOR_W'(32'(xs) >> GRAD_SHIFT);
  assign chk  = (((xs ^ v_cnt) >> CHECK_LOG2) & 12'd1) != 12'd0;

  // Bar index is floor(x*8/H_ACTIVE), found by threshold compares instead of a divider.
  always_comb begin
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (int'(h_cnt) * 8 >= k * H_ACTIVE) begin
        bar_idx = 3'(k);
      end
    end
  end

  always_comb begin
    r_n = '0;
    g_n = '0;
    b_n = '0;
    if (active) begin
      case (mode_q)
        3'd1: begin
          r_n = {COLOR_W{~bar_idx[1]}};
          g_n = {COLOR_W{~bar_idx[2]}};
          b_n = {COLOR_W{~bar_idx[0]}};
        end
        3'd2: begin
          r_n = grey;
          g_n = grey;
          b_n = grey;
        end
        3'd3: begin
          r_n = {COLOR_W{chk}};
          g_n = {COLOR_W{chk}};
          b_n = {COLOR_W{chk}};
        end
        3'd4: begin
          r_n = '1;
          g_n = '1;
          b_n = '1;
        end
        default: begin
          r_n = '0;
          g_n = '0;
          b_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt           <= '0;
      v_cnt           <= '0;
      mode_q          <= '0;
      vid.de          <= 1'b0;
      vid.hs          <= ~HS_POL;
      vid.vs          <= ~VS_POL;
      vid.r           <= '0;
      vid.g           <= '0;
      vid.b           <= '0;
      vid.x           <= '0;
      vid.y           <= '0;
      vid.line_start  <= 1'b0;
      vid.frame_start <= 1'b0;
    end else if (vid.en) begin
      h_cnt <= h_last ? 12'd0 : h_cnt + 12'd1;
      if (h_last) begin
        v_cnt <= v_last ? 12'd0 : v_cnt + 12'd1;
      end
      if (h_last && v_last) begin
        mode_q <= vid.mode;
      end
      vid.de <= active;
      vid.hs <= (h_cnt >= HS_FIRST && h_cnt <= HS_LAST) ? HS_POL : ~HS_POL;
      vid.vs <= (v_cnt >= VS_FIRST && v_cnt <= VS_LAST) ? VS_POL : ~VS_POL;
      vid.r  <= r_n;
      vid.g  <= g_n;
      vid.b  <= b_n;
      // Coordinates keep the last active pixel through blanking.
      if (active) begin
        vid.x <= h_cnt;
        vid.y <= v_cnt;
      end
      vid.line_start  <= active && (h_cnt == 12'd0);
      vid.frame_start <= active && (h_cnt == 12'd0) && (v_cnt == 12'd0);
    end
  end
endmodule

// File: doc/video_timing_pattern_gen.md
Name: video_timing_pattern_gen

Overview:
Parametrised video timing and test-pattern generator, successor to the fixed-mode HDMI pattern generator. Runs in the pixel clock domain and drives the HDMI transmitter's de/hs/vs/RGB bus. Resolution, porches, sync polarity and colour depth are set by parameters. Supports five runtime-selectable patterns, switched glitch-free at frame boundaries, plus pixel coordinates and frame/line strobes for downstream overlay logic.

Parameters:
H_ACTIVE, 640, active pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, asserted level of hs (0 = active-low)
VS_POL, 0, asserted level of vs
COLOR_W, 8, bits per colour channel
GRAD_SHIFT, 2, right-shift of x applied for the gradient pattern
CHECK_LOG2, 5, log2 of checkerboard cell size in pixels

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous reset, active-high
en  in  1  clock enable; 0 holds all state
mode  in  3  pattern select; sampled once per frame
de  out  1  data enable, high in the active region
hs  out  1  horizontal sync
vs  out  1  vertical sync
r  out  COLOR_W  red
g  out  COLOR_W  green
b  out  COLOR_W  blue
x  out  12  active pixel column, valid when de=1
y  out  12  active line, valid when de=1
line_start  out  1  1-cycle pulse with the first active pixel of each line
frame_start  out  1  1-cycle pulse with pixel (0,0)

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. h_cnt runs 0..H_TOTAL-1 and wraps to 0. v_cnt increments when h_cnt wraps and itself wraps from V_TOTAL-1 to 0.
- Active region: h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
- hs = HS_POL for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], else ~HS_POL.
- vs = VS_POL for whole lines with v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], else ~VS_POL. vs edges coincide with h_cnt=0.
- Latency: every output is registered. Outputs in cycle n+1 reflect counter values in cycle n. de, hs, vs, RGB, x, y and the strobes are mutually aligned.
- Outside the active region: r=g=b=0, and x/y hold their last values.
- Mode latch: mode_q <= mode when h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1. A mid-frame change of mode takes effect from the next frame's pixel (0,0).
- Patterns (M = 2^COLOR_W-1):
  - 0: black.
  - 1: eight equal-width vertical colour bars. Bar index = floor(x*8/H_ACTIVE). Order: white, yellow, cyan, green, magenta, red, blue, black, built from full-scale M/0 channel values.
  - 2: grey ramp, r=g=b=(x>>GRAD_SHIFT) truncated to COLOR_W bits.
  - 3: checkerboard, white when ((x>>CHECK_LOG2)^(y>>CHECK_LOG2))&1, else black.
  - 4: solid white.
  - 5-7: treated as 0.
- en=0: counters, mode_q and all output registers hold. Strobes do not re-pulse while held.
- Reset (asynchronous, any time including mid-frame):
  - h_cnt=v_cnt=0, mode_q=0.
  - de=0, hs=~HS_POL, vs=~VS_POL, r=g=b=0, x=y=0, strobes=0.
  - After reset deasserts, the first active pixel (0,0) appears one cycle after the first enabled clock, with frame_start=1.
- Parameter check: H_ACTIVE and V_ACTIVE must be <=4095. The totals must fit in 12-bit counters; elaboration fails otherwise.

Optional Feature:
Macro VTPG_ANIMATE_EN.
- Defined: a 12-bit offset register increments by 1 (wrapping mod 4096) at each frame boundary, i.e. the same cycle mode_q is sampled. Patterns 2 and 3 use (x+offset) in place of x, so the ramp and checkerboard scroll left one pixel per frame. Offset resets to 0 and holds while en=0.
- Undefined: no offset register is built, and all patterns are static.

Test Plan:
- Defaults, mode=0, en=1 after reset -> de high for exactly 640 consecutive cycles per line and 480 lines per frame. Each hs low pulse lasts 96 cycles, starting 656 cycles after de rises. Period is 800 cycles per line and 420000 per frame.
- mode=1 -> at x=79 RGB=FF,FF,FF; at x=80 FF,FF,00; at x=639 00,00,00. Every line identical.
- mode changed 0->3 at line 200 -> remainder of that frame stays black. Next frame pixel (0,0) is black, (32,0) is white, (32,32) is black.
- en deasserted for 50 cycles mid-line at x=300 -> all outputs frozen for those cycles. On resume x continues at 301 and line length is unchanged.
- reset asserted at line 100, pixel 400 -> outputs take reset values immediately. After release, frame_start pulses with x=0, y=0 one cycle after the first enabled clock.
- With VTPG_ANIMATE_EN, mode=2 -> pixel x=4 reads 01 in frame 0, and the same pixel reads 01 at x=3 in frame 1. Without the macro, frame 1 matches frame 0 exactly.
